mems_saw_gen: RTL

Sawtooth scan generator upstream of the MEMS SPI master: on every sample tick it emits two 24-bit DAC frames (X channel, then Y channel) through the SPI master's start/busy/new_data handshake. X ramps at a fixed step per sample and wraps; Y advances one step per X wrap, giving a raster. Sits between the host control logic (run, step values) and the SPI master driving the MEMS mirror DAC.

---
 rtl/mems_pkg.sv | 29 ++
 rtl/mems_sample_tick.sv | 35 +++
 rtl/mems_saw_gen.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mems_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mems_pkg
// Description : Shared DAC frame constants, FSM state encoding and frame builder.
// Revision    : 1.0
// ============================================================================
package mems_pkg;

    localparam int          FRAME_W          = 24;
    localparam logic [2:0]  CMD_WRITE_UPDATE = 3'b011;
    localparam logic [2:0]  ADDR_X           = 3'b000;
    localparam logic [2:0]  ADDR_Y           = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_SEND_X    = 3'd2,
        ST_WAIT_X    = 3'd3,
        ST_SEND_Y    = 3'd4,
        ST_WAIT_Y    = 3'd5
    } state_t;

    function automatic logic [FRAME_W-1:0] make_frame(input logic [2:0]  addr,
                                                      input logic [15:0] code);
        return {2'b00, CMD_WRITE_UPDATE, addr, code};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mems_sample_tick.sv
`default_nettype none
// ============================================================================
// Module      : mems_sample_tick
// Description : Free-running 0..SAMPLE_DIV-1 counter with synchronous clear;
//               tick_o is high for the cycle holding the terminal count.
// Revision    : 1.0
// ============================================================================
module mems_sample_tick #(
    parameter int SAMPLE_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int              CNT_W    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = !clear_i && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/mems_saw_gen.sv
`default_nettype none
// ============================================================================
// Module      : mems_saw_gen
// Description : Raster scan generator; per sample tick sends an X then a Y DAC
//               frame through the SPI master handshake. Define
//               MEMS_SAW_BIDIR_EN for a triangular (up/down) X sweep.
// Revision    : 1.0
// ============================================================================
module mems_saw_gen
    import mems_pkg::*;
#(
    parameter int          SAMPLE_DIV = 50000,
    parameter logic [15:0] X_MAX      = 16'hFFFF,
    parameter logic [15:0] Y_MAX      = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [15:0]        x_step,
    input  logic [15:0]        y_step,
    input  logic               spi_busy,
    input  logic               spi_new_data,
    output logic               start,
    output logic [FRAME_W-1:0] data_out,
    output logic [15:0]        x_pos,
    output logic [15:0]        y_pos,
    output logic               frame_done,
    output logic               overrun
);

    state_t             state_q, state_d;
    logic               pending_q, pending_d;
    logic [15:0]        xs_q, xs_d, ys_q, ys_d;
    logic [15:0]        x_q, x_d, y_q, y_d;
    logic               start_q, start_d;
    logic [FRAME_W-1:0] data_q, data_d;
    logic               fd_q, fd_d, ov_q, ov_d;
    logic               tick_clear, sample_tick, tick_take, x_turn;
    logic [16:0]        x_sum, y_sum;
`ifdef MEMS_SAW_BIDIR_EN
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    logic dir_q, dir_d;
`endif

    assign tick_clear = (state_q == ST_IDLE);

    mems_sample_tick #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (tick_clear),
        .tick_o  (sample_tick)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        xs_d      = xs_q;
        ys_d      = ys_q;
        x_d       = x_q;
        y_d       = y_q;
        start_d   = 1'b0;
        data_d    = data_q;
        fd_d      = 1'b0;
        ov_d      = 1'b0;
        tick_take = 1'b0;
        x_turn    = 1'b0;
        x_sum     = {1'b0, x_q} + {1'b0, xs_q};
        y_sum     = {1'b0, y_q} + {1'b0, ys_q};
`ifdef MEMS_SAW_BIDIR_EN
        dir_d     = dir_q;
`endif
        case (state_q)
            ST_IDLE: begin
                x_d = '0;
                y_d = '0;
`ifdef MEMS_SAW_BIDIR_EN
                dir_d = DIR_UP;
`endif
                if (run) begin
                    xs_d    = x_step;
                    ys_d    = y_step;
                    state_d = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                // Stopping takes priority over a waiting tick.
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (pending_q) begin
                    tick_take = 1'b1;
                    state_d   = ST_SEND_X;
                end
            end
            ST_SEND_X: begin
                if (!spi_busy) begin
                    start_d = 1'b1;
                    data_d  = make_frame(ADDR_X, x_q);
                    state_d = ST_WAIT_X;
                end
            end
            ST_WAIT_X: begin
                if (spi_new_data) state_d = ST_SEND_Y;
            end
            ST_SEND_Y: begin
                if (!spi_busy) begin
                    start_d = 1'b1;
                    data_d  = make_frame(ADDR_Y, y_q);
                    state_d = ST_WAIT_Y;
                end
            end
            ST_WAIT_Y: begin
                if (spi_new_data) begin
                    state_d = ST_WAIT_TICK;
`ifdef MEMS_SAW_BIDIR_EN
                    if (dir_q == DIR_UP) begin
                        if ((xs_q != 16'd0) && (x_sum >= {1'b0, X_MAX})) begin
                            x_d    = X_MAX;
                            dir_d  = DIR_DOWN;
                            x_turn = 1'b1;
                        end else begin
                            x_d = x_sum[15:0];
                        end
                    end else begin
                        if ((xs_q != 16'd0) && (x_q <= xs_q)) begin
                            x_d    = '0;
                            dir_d  = DIR_UP;
                            x_turn = 1'b1;
                        end else begin
                            x_d = x_q - xs_q;
                        end
                    end
`else
                    if (x_sum > {1'b0, X_MAX}) begin
                        x_d    = '0;
                        x_turn = 1'b1;
                    end else begin
                        x_d = x_sum[15:0];
                    end
`endif
                    // Y uses the step latched for this line; new steps apply to the next one.
                    if (x_turn) begin
                        xs_d = x_step;
                        ys_d = y_step;
                        if (y_sum > {1'b0, Y_MAX}) begin
                            y_d  = '0;
                            fd_d = 1'b1;
                        end else begin
                            y_d = y_sum[15:0];
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_IDLE) begin
            pending_d = 1'b0;
        end else if (sample_tick) begin
            ov_d      = pending_q & ~tick_take;
            pending_d = 1'b1;
        end else if (tick_take) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            xs_q      <= '0;
            ys_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            start_q   <= 1'b0;
            data_q    <= '0;
            fd_q      <= 1'b0;
            ov_q      <= 1'b0;
`ifdef MEMS_SAW_BIDIR_EN
            dir_q     <= DIR_UP;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            xs_q      <= xs_d;
            ys_q      <= ys_d;
            x_q       <= x_d;
            y_q       <= y_d;
            start_q   <= start_d;
            data_q    <= data_d;
            fd_q      <= fd_d;
            ov_q      <= ov_d;
`ifdef MEMS_SAW_BIDIR_EN
            dir_q     <= dir_d;
`endif
        end
    end

    assign start      = start_q;
    assign data_out   = data_q;
    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign frame_done = fd_q;
    assign overrun    = ov_q;

endmodule
`default_nettype wire
